// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative multiplier slice.
package mult_pkg;

  // Controller states: waiting for operands, accumulating rows, holding the product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the row counter; it only has to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_array_multiplier_pp_row_add.sv
// One partial-product row: adds (mag << shift) into the accumulator when the
// multiplier bit for this row is set. Replaces a full row of the old array.
module pp_row_add #(
  parameter int WIDTH = 4,
  parameter int CW    = 2
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mag,
  input  logic               en,
  input  logic [CW-1:0]      shift,
  output logic [2*WIDTH-1:0] sum
);

  logic [2*WIDTH-1:0] row;

  // Shift the zero-extended multiplicand into place and add it if enabled.
  always_comb begin
    row = {{WIDTH{1'b0}}, mag} << shift;
    sum = en ? (acc + row) : acc;
  end

endmodule

// File: rtl/seq_array_multiplier.sv
// Iterative WIDTH x WIDTH multiplier, one partial-product row per clock,
// with valid/ready handshakes on both sides. Signed operands are handled by
// multiplying magnitudes and negating the result at the end.
module seq_array_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last_row;

  assign last_row = (cnt == CW'(WIDTH - 1));

  pp_row_add #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_row (
    .acc   (acc),
    .mag   (mag_a),
    .en    (mag_b[cnt]),
    .shift (cnt),
    .sum   (acc_sum)
  );

  // State register; reset abandons any in-flight product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: accept in IDLE, run WIDTH rows, wait for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_row)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == BUSY) || (state == DONE);
  end

  // Operand capture, row accumulation and the signed fix-up into p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_a <= (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
            mag_b <= (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt   <= '0;
            acc   <= '0;
          end
        end
        BUSY: begin
          acc <= acc_sum;
          cnt <= cnt + CW'(1);
          if (last_row) p <= neg ? (~acc_sum + 1'b1) : acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Randomised and directed checks of seq_array_multiplier at WIDTH=4 and 16
// against an arithmetic reference model.
module tb_seq_array_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        v4 = 1'b0, s4 = 1'b0, or4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ir4, ov4, busy4;
  logic [7:0]  p4;

  logic        v16 = 1'b0, s16 = 1'b0, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ir16, ov16, busy16;
  logic [31:0] p16;

  int vectors = 0;
  int miscompares = 0;

  seq_array_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
  );

  seq_array_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .p(p16), .busy(busy16)
  );

  always #5 clk = ~clk;

  // Reference: interpret operands as integers and multiply, keep 2*w bits.
  function automatic logic [63:0] refProduct(input longint x, input longint y,
                                             input bit s, input int w);
    longint half, xs, ys, prod;
    logic [63:0] mask;
    half = longint'(1) << (w - 1);
    xs = s ? ((x ^ half) - half) : x;
    ys = s ? ((y ^ half) - half) : y;
    prod = xs * ys;
    mask = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return 64'(prod) & mask;
  endfunction

  // Count one comparison and report it if it mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // One WIDTH=4 transaction: optional junk inputs while busy, optional DONE stall.
  task automatic applyStimulus4(input logic [3:0] ta, input logic [3:0] tb,
                                input logic ts, input int hold, input bit junk);
    int lat;
    logic [63:0] want;
    want = refProduct(longint'(ta), longint'(tb), ts, 4);
    @(negedge clk);
    a4 = ta; b4 = tb; s4 = ts; v4 = 1'b1; or4 = 1'b0;
    checkOutput("w4_in_ready_idle", 64'(ir4), 64'd1);
    @(posedge clk); #1;
    if (junk) begin
      a4 = ~ta; b4 = tb + 4'd1; s4 = ~ts; v4 = 1'b1;
    end else begin
      v4 = 1'b0;
    end
    lat = 0;
    while (!ov4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("w4_latency", 64'(lat), 64'd4);
    checkOutput("w4_product", 64'(p4), want);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("w4_hold_p", 64'(p4), want);
      checkOutput("w4_hold_valid", 64'(ov4), 64'd1);
      checkOutput("w4_hold_in_ready", 64'(ir4), 64'd0);
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0; v4 = 1'b0;
    checkOutput("w4_handoff_valid", 64'(ov4), 64'd0);
    checkOutput("w4_back_idle", 64'(ir4), 64'd1);
  endtask

  // One WIDTH=16 transaction with a randomly stalling consumer.
  task automatic applyStimulus16(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic ts);
    int lat;
    bit taken;
    logic [63:0] want;
    want = refProduct(longint'(ta), longint'(tb), ts, 16);
    @(negedge clk);
    a16 = ta; b16 = tb; s16 = ts; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("w16_latency", 64'(lat), 64'd16);
    taken = 1'b0;
    lat = 0;
    while (!taken && lat < 40) begin
      @(negedge clk);
      or16 = (lat >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      checkOutput("w16_product", 64'(p16), want);
      checkOutput("w16_valid", 64'(ov16), 64'd1);
      @(posedge clk); #1;
      if (or16) taken = 1'b1;
      lat++;
    end
    or16 = 1'b0;
    checkOutput("w16_released", 64'(ov16), 64'd0);
  endtask

  initial begin
    $display("[TB] start");
    #12;
    checkOutput("rst_out_valid", 64'(ov4), 64'd0);
    checkOutput("rst_p", 64'(p4), 64'd0);
    checkOutput("rst_busy", 64'(busy4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(ir4), 64'd1);

    // Directed corner cases.
    applyStimulus4(4'hF, 4'hF, 1'b0, 0, 1'b0);
    applyStimulus4(4'h8, 4'h8, 1'b1, 0, 1'b0);
    applyStimulus4(4'hD, 4'h5, 1'b1, 0, 1'b0);
    applyStimulus4(4'h0, 4'hD, 1'b0, 0, 1'b0);
    applyStimulus4(4'h6, 4'hB, 1'b1, 3, 1'b1);
    applyStimulus4(4'h8, 4'h7, 1'b1, 2, 1'b1);
    checkOutput("const_15x15", 64'(refProduct(64'd15, 64'd15, 1'b0, 4)), 64'h00E1);

    // Reset in the middle of accumulation discards the product.
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; s4 = 1'b0; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midbusy_rst_valid", 64'(ov4), 64'd0);
    checkOutput("midbusy_rst_p", 64'(p4), 64'd0);
    checkOutput("midbusy_rst_busy", 64'(busy4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midbusy_rst_in_ready", 64'(ir4), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midbusy_no_resume", 64'(ov4), 64'd0);
    applyStimulus4(4'h7, 4'h9, 1'b0, 0, 1'b0);

    // Reset while a product sits unaccepted in DONE.
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h5; s4 = 1'b0; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("done_before_rst", 64'(ov4), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("done_rst_valid", 64'(ov4), 64'd0);
    checkOutput("done_rst_p", 64'(p4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep of both modes at WIDTH=4.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          applyStimulus4(4'(i), 4'(j), 1'(m), 0, 1'b0);

    // Random WIDTH=16 traffic, including the extreme operands.
    applyStimulus16(16'h8000, 16'h8000, 1'b1);
    applyStimulus16(16'hFFFF, 16'hFFFF, 1'b0);
    applyStimulus16(16'h8000, 16'h7FFF, 1'b1);
    for (int k = 0; k < 60; k++)
      applyStimulus16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
